// File: rtl/fifo3_rd_seq.sv
// Purpose: read-side sequencer for fifo3; pops the head entry, latches its fields and requests NSAMP SCA samples.
// Latency: POP two cycles after IDLE sees EMPTY=0, first sample one cycle later, NSAMP+4 cycles IDLE to IDLE.
// Backpressure: RDY=0 stalls sample requests; CER=0 freezes everything. Optional build macro: SKIP_SCAFULL_EN.
module fifo3_rd_seq #(
    parameter int NSAMP = 8,
    parameter int TMR   = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CER,
    input  logic       EMPTY,
    input  logic [3:0] BLKIN,
    input  logic [7:0] L1PIN,
    input  logic       LCT_PH_IN,
    input  logic       SCAFULL_IN,
    input  logic       SCND_BLK_IN,
    input  logic       SCND_SH_IN,
    input  logic       RDY,
    output logic       POP,
    output logic [3:0] BLK_ADDR,
    output logic [7:0] L1P,
    output logic       LCT_PH,
    output logic       SCAFULL,
    output logic       SCND_SH,
    output logic       SMP_STB,
    output logic [3:0] SMP_IDX,
    output logic       EVT_START,
    output logic       BLK_DONE,
    output logic       EVT_CONT,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CAP  = 3'd2,
        S_XFER = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NSAMP - 1);

    // Three copies of state and index; copies 1/2 only matter when TMR is set.
    state_t     st0_q, st1_q, st2_q;
    state_t     st_v, st_d;
    logic [3:0] idx0_q, idx1_q, idx2_q;
    logic [3:0] idx_v, idx_d;

    logic [3:0] blk_q;
    logic [7:0] l1p_q;
    logic       lct_q;
    logic       scaf_q;
    logic       scnd_sh_q;
    logic       scnd_blk_q;
    logic       evt_cont_q;

    function automatic logic [2:0] vote3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [3:0] vote4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over the redundant copies, or plain copy 0 without TMR.
    always_comb begin
        if (TMR != 0) begin
            st_v  = state_t'(vote3(st0_q, st1_q, st2_q));
            idx_v = vote4(idx0_q, idx1_q, idx2_q);
        end else begin
            st_v  = st0_q;
            idx_v = idx0_q;
        end
    end

    // Next-state and sample index; a corrupted voted state falls back to IDLE.
    always_comb begin
        st_d  = st_v;
        idx_d = idx_v;
        case (st_v)
            S_IDLE: begin
                if (!EMPTY) st_d = S_WAIT;
            end
            S_WAIT: begin
                // EMPTY rising here means the entry vanished: never pop it.
                st_d = EMPTY ? S_IDLE : S_CAP;
            end
            S_CAP: begin
                idx_d = 4'd0;
                st_d  = S_XFER;
`ifdef SKIP_SCAFULL_EN
                if (SCAFULL_IN) st_d = S_FIN;
`endif
            end
            S_XFER: begin
                if (RDY) begin
                    if (idx_v == LAST_IDX) st_d = S_FIN;
                    else                   idx_d = idx_v + 4'd1;
                end
            end
            S_FIN: begin
                st_d = S_IDLE;
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    // State, index and latched entry fields; CER=0 holds everything.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            st0_q      <= S_IDLE;
            st1_q      <= S_IDLE;
            st2_q      <= S_IDLE;
            idx0_q     <= 4'd0;
            idx1_q     <= 4'd0;
            idx2_q     <= 4'd0;
            blk_q      <= 4'd0;
            l1p_q      <= 8'd0;
            lct_q      <= 1'b0;
            scaf_q     <= 1'b0;
            scnd_sh_q  <= 1'b0;
            scnd_blk_q <= 1'b0;
            evt_cont_q <= 1'b0;
        end else if (CER) begin
            st0_q  <= st_d;
            st1_q  <= st_d;
            st2_q  <= st_d;
            idx0_q <= idx_d;
            idx1_q <= idx_d;
            idx2_q <= idx_d;
            if (st_v == S_CAP) begin
                blk_q      <= BLKIN;
                l1p_q      <= L1PIN;
                lct_q      <= LCT_PH_IN;
                scaf_q     <= SCAFULL_IN;
                scnd_sh_q  <= SCND_SH_IN;
                scnd_blk_q <= SCND_BLK_IN;
            end
            // The event continues into the next entry only if this block said so.
            if (st_v == S_FIN) evt_cont_q <= scnd_blk_q;
        end
    end

    // Strobes are decoded from registered state and gated by the clock enable.
    always_comb begin
        POP       = CER && (st_v == S_CAP);
        EVT_START = CER && (st_v == S_CAP) && !evt_cont_q;
        SMP_STB   = CER && (st_v == S_XFER) && RDY;
        BLK_DONE  = CER && (st_v == S_FIN);
        BUSY      = (st_v != S_IDLE);
        SMP_IDX   = idx_v;
        BLK_ADDR  = blk_q;
        L1P       = l1p_q;
        LCT_PH    = lct_q;
        SCAFULL   = scaf_q;
        SCND_SH   = scnd_sh_q;
        EVT_CONT  = evt_cont_q;
    end

endmodule

// File: tb/tb_fifo3_rd_seq.sv
// Bench for fifo3_rd_seq: directed entries, scoreboard queues of expected POP,
// sample and block-done events, popped by a negedge monitor.
module tb_fifo3_rd_seq;

    localparam int NSAMP = 8;

    typedef struct packed {
        logic [3:0] blk;
        logic [7:0] l1p;
        logic       lct;
        logic       scaf;
        logic       sblk;
        logic       ssh;
    } entry_t;

    typedef struct {
        int   cyc;
        logic es;
    } pop_exp_t;

    typedef struct {
        int     cyc;
        entry_t e;
    } done_exp_t;

    logic       CLK = 1'b0;
    logic       RST, CER, EMPTY, LCT_PH_IN, SCAFULL_IN, SCND_BLK_IN, SCND_SH_IN, RDY;
    logic [3:0] BLKIN;
    logic [7:0] L1PIN;
    logic       POP, LCT_PH, SCAFULL, SCND_SH, SMP_STB, EVT_START, BLK_DONE, EVT_CONT, BUSY;
    logic [3:0] BLK_ADDR, SMP_IDX;
    logic [7:0] L1P;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pop_exp_t  pop_q[$];
    int        strb_q[$];
    done_exp_t done_q[$];
    logic      pend_cont = 1'b0;
    logic      pend_val  = 1'b0;

    fifo3_rd_seq #(.NSAMP(NSAMP), .TMR(0)) dut (
        .CLK(CLK), .RST(RST), .CER(CER), .EMPTY(EMPTY),
        .BLKIN(BLKIN), .L1PIN(L1PIN), .LCT_PH_IN(LCT_PH_IN), .SCAFULL_IN(SCAFULL_IN),
        .SCND_BLK_IN(SCND_BLK_IN), .SCND_SH_IN(SCND_SH_IN), .RDY(RDY),
        .POP(POP), .BLK_ADDR(BLK_ADDR), .L1P(L1P), .LCT_PH(LCT_PH), .SCAFULL(SCAFULL),
        .SCND_SH(SCND_SH), .SMP_STB(SMP_STB), .SMP_IDX(SMP_IDX), .EVT_START(EVT_START),
        .BLK_DONE(BLK_DONE), .EVT_CONT(EVT_CONT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Queue the full response for one entry. stall<0 leaves the done cycle unchecked.
    task automatic expect_block(input entry_t e, input int pop_cyc, input logic es,
                                input int stall, input bit with_done);
        pop_exp_t  pe;
        done_exp_t de;
        int        nsmp;
        nsmp = NSAMP;
`ifdef SKIP_SCAFULL_EN
        if (e.scaf) nsmp = 0;
`endif
        pe.cyc = pop_cyc;
        pe.es  = es;
        pop_q.push_back(pe);
        for (int i = 0; i < nsmp; i++) strb_q.push_back(i);
        if (with_done) begin
            de.cyc = (stall < 0) ? -1 : pop_cyc + 1 + nsmp + stall;
            de.e   = e;
            done_q.push_back(de);
        end
    endtask

    task automatic present(input entry_t e);
        BLKIN       = e.blk;
        L1PIN       = e.l1p;
        LCT_PH_IN   = e.lct;
        SCAFULL_IN  = e.scaf;
        SCND_BLK_IN = e.sblk;
        SCND_SH_IN  = e.ssh;
        EMPTY       = 1'b0;
    endtask

    task automatic wait_pop();
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge CLK);
            if (POP) break;
            n++;
        end
        if (n >= 40) chk("pop_timeout", n, 0);
        @(posedge CLK); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge CLK);
            if (!BUSY) break;
            n++;
        end
        if (n >= 60) chk("idle_timeout", n, 0);
        @(posedge CLK); #1;
    endtask

    // Scoreboard monitor: every DUT-presented event pops and checks its expectation.
    always @(negedge CLK) begin
        pop_exp_t  pe;
        done_exp_t de;
        int        si;
        if (pend_cont) begin
            chk("evt_cont", EVT_CONT, pend_val);
            pend_cont = 1'b0;
        end
        if (POP) begin
            if (pop_q.size() == 0) chk("pop_stray", POP, 0);
            else begin
                pe = pop_q.pop_front();
                if (pe.cyc >= 0) chk("pop_cyc", cyc, pe.cyc);
                chk("evt_start", EVT_START, pe.es);
                chk("pop_empty", EMPTY, 0);
            end
        end else if (EVT_START) chk("evt_start_stray", EVT_START, 0);
        if (SMP_STB) begin
            chk("stb_rdy", RDY, 1);
            if (strb_q.size() == 0) chk("stb_stray", SMP_STB, 0);
            else begin
                si = strb_q.pop_front();
                chk("smp_idx", SMP_IDX, si);
            end
        end
        if (BLK_DONE) begin
            if (done_q.size() == 0) chk("done_stray", BLK_DONE, 0);
            else begin
                de = done_q.pop_front();
                if (de.cyc >= 0) chk("done_cyc", cyc, de.cyc);
                chk("done_fields", {BLK_ADDR, L1P, LCT_PH, SCAFULL, SCND_SH},
                    {de.e.blk, de.e.l1p, de.e.lct, de.e.scaf, de.e.ssh});
                pend_cont = 1'b1;
                pend_val  = de.e.sblk;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t e, e2;
        int     t0;
        bit     done;

        RST = 1'b0; CER = 1'b1; EMPTY = 1'b1; RDY = 1'b1;
        BLKIN = 4'h0; L1PIN = 8'h00; LCT_PH_IN = 1'b0; SCAFULL_IN = 1'b0;
        SCND_BLK_IN = 1'b0; SCND_SH_IN = 1'b0;

        // Power-on reset state.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst0_outs", {POP, BLK_ADDR, L1P, LCT_PH, SCAFULL, SCND_SH, SMP_STB, SMP_IDX, EVT_START, BLK_DONE, EVT_CONT}, 0);
        chk("rst0_busy", BUSY, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // Single entry, RDY high: POP at 2, strobes 3..10, BLK_DONE at 11.
        e = '{4'hA, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1};
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b1, 0, 1'b1);
        wait_pop(); EMPTY = 1'b1;
        wait_idle();

        // RDY pattern 1,0,0 repeating.
        e = '{4'h3, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0};
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b1, -1, 1'b1);
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            RDY = (k % 3 == 0);
            if (k == 3) EMPTY = 1'b1;
            @(negedge CLK);
            if (k > 3 && !BUSY) begin done = 1'b1; break; end
            @(posedge CLK); #1;
        end
        if (!done) chk("rdy_toggle_timeout", BUSY, 0);
        @(posedge CLK); #1;
        RDY = 1'b1;

        // CER low for 5 cycles while SMP_IDX=3.
        e = '{4'h5, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0};
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b1, 5, 1'b1);
        repeat (3) @(posedge CLK); #1;
        EMPTY = 1'b1;
        repeat (3) @(posedge CLK); #1;
        CER = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            chk("cer_idx", SMP_IDX, 3);
            chk("cer_strobes", {SMP_STB, POP, BLK_DONE, EVT_START}, 0);
            @(posedge CLK); #1;
        end
        CER = 1'b1;
        wait_idle();

        // Block with SCND_BLK=1 leaves EVT_CONT set; next entry gets no EVT_START, then reset mid-block.
        e = '{4'hC, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b1};
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b1, 0, 1'b1);
        wait_pop(); EMPTY = 1'b1;
        wait_idle();
        e = '{4'h9, 8'h3F, 1'b1, 1'b1, 1'b1, 1'b1};
        e.scaf = 1'b0;
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b0, 0, 1'b0);
        repeat (5) @(posedge CLK); #1;
        EMPTY = 1'b1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        strb_q.delete();
        @(negedge CLK);
        chk("rst1_outs", {POP, BLK_ADDR, L1P, LCT_PH, SCAFULL, SCND_SH, SMP_STB, SMP_IDX, EVT_START, BLK_DONE, EVT_CONT}, 0);
        chk("rst1_busy", BUSY, 0);
        repeat (4) @(posedge CLK); #1;

        // Two-block event: back-to-back entries, second starts at cycle 12.
        e  = '{4'h1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0};
        e2 = '{4'h2, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1};
        present(e); t0 = cyc;
        expect_block(e,  t0 + 2,  1'b1, 0, 1'b1);
        expect_block(e2, t0 + 14, 1'b0, 0, 1'b1);
        wait_pop();
        present(e2);
        wait_pop(); EMPTY = 1'b1;
        wait_idle();

        // SCAFULL entry: skipped or fully sampled depending on the build.
        e = '{4'h7, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        present(e); t0 = cyc;
        expect_block(e, t0 + 2, 1'b1, 0, 1'b1);
        wait_pop(); EMPTY = 1'b1;
        wait_idle();

        repeat (5) @(posedge CLK); #1;
        chk("pop_left",  pop_q.size(),  0);
        chk("strb_left", strb_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("final_busy", BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
